// File: rtl/iter_func_unit.sv
// rtl/iter_func_unit.sv - multi-cycle MULT / FACT / PARITY engine behind valid/ready ports
module iter_func_unit #(
    parameter int WIDTH  = 32,
    parameter int RWIDTH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RWIDTH-1:0] out_result,
    output logic              out_ovf,
    output logic              out_err,
    output logic              busy
);

    localparam logic [1:0] MODE_MULT = 2'b00;
    localparam logic [1:0] MODE_FACT = 2'b01;
    localparam logic [1:0] MODE_PAR  = 2'b10;
    localparam int         PWIDTH    = RWIDTH + WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_mode;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_i;
    logic [WIDTH-1:0]    r_cnt;
    logic [RWIDTH-1:0]   r_mcand;
    logic [RWIDTH-1:0]   r_acc;
    logic                r_ovf;
    logic                r_err;

    logic                w_accept;
    logic                w_last;
    logic [PWIDTH-1:0]   w_fact_prod;
    logic                w_fact_ovf;
    logic                w_fact_trivial;

    assign w_accept       = (r_state == S_IDLE) && in_valid;
    assign w_fact_prod    = {{WIDTH{1'b0}}, r_acc} * {{RWIDTH{1'b0}}, r_i};
    assign w_fact_ovf     = |w_fact_prod[PWIDTH-1:RWIDTH];
    assign w_fact_trivial = (r_a <= WIDTH'(1));

    // Last CALC cycle: the transition to DONE happens on this edge.
    always_comb begin
        w_last = 1'b1;
        case (r_mode)
            MODE_MULT: w_last = (r_cnt == WIDTH'(WIDTH - 1));
            MODE_FACT: w_last = w_fact_trivial || w_fact_ovf || (r_i == r_a);
            default:   w_last = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_CALC;
            S_CALC:  if (w_last) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= MODE_MULT;
            r_a     <= '0;
            r_b     <= '0;
            r_i     <= '0;
            r_cnt   <= '0;
            r_mcand <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_mode  <= in_mode;
            r_a     <= in_a;
            r_b     <= in_b;
            r_i     <= WIDTH'(2);
            r_cnt   <= '0;
            r_mcand <= {{(RWIDTH - WIDTH){1'b0}}, in_a};
            r_acc   <= (in_mode == MODE_FACT) ? RWIDTH'(1) : '0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + WIDTH'(1);
            case (r_mode)
                MODE_MULT: begin
                    if (r_b[0]) r_acc <= r_acc + r_mcand;
                    r_mcand <= r_mcand << 1;
                    r_b     <= r_b >> 1;
                end
                MODE_FACT: begin
                    // 0! and 1! keep the seed value of 1.
                    if (!w_fact_trivial) begin
                        r_acc <= w_fact_prod[RWIDTH-1:0];
                        r_ovf <= w_fact_ovf;
                        if (r_i != r_a) r_i <= r_i + WIDTH'(1);
                    end
                end
                MODE_PAR: begin
                    r_acc <= {{(RWIDTH - 1){1'b0}}, ^r_a};
                end
                default: begin
                    r_acc <= '0;
                    r_err <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);
    assign out_result = r_acc;
    assign out_ovf    = r_ovf;
    assign out_err    = r_err;

endmodule

// File: tb/tb_iter_func_unit.sv
// tb/tb_iter_func_unit.sv - directed vector bench for iter_func_unit
module tb_iter_func_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        out_ovf;
    logic        out_err;
    logic        busy;

    int n_checks;
    int n_fail;

    iter_func_unit #(.WIDTH(32), .RWIDTH(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf),
        .out_err    (out_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        logic        ovf;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue a request and return edges from accept to out_valid (-1 on timeout).
    task automatic issue(input logic [1:0] mode, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        in_mode  = mode;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            if (out_valid) begin
                lat = k - 1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [63:0] held;
        logic        seen;

        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 2'b00;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        vecs[0]  = '{"mult_7x6",    2'b00, 32'd7,         32'd6,       64'd42,                   1'b0, 1'b0, 32};
        vecs[1]  = '{"fact_5",      2'b01, 32'd5,         32'd0,       64'd120,                  1'b0, 1'b0, 4};
        vecs[2]  = '{"fact_0",      2'b01, 32'd0,         32'd9,       64'd1,                    1'b0, 1'b0, 1};
        vecs[3]  = '{"fact_1",      2'b01, 32'd1,         32'd0,       64'd1,                    1'b0, 1'b0, 1};
        vecs[4]  = '{"fact_2",      2'b01, 32'd2,         32'd0,       64'd2,                    1'b0, 1'b0, 1};
        vecs[5]  = '{"fact_3",      2'b01, 32'd3,         32'd0,       64'd6,                    1'b0, 1'b0, 2};
        vecs[6]  = '{"fact_20",     2'b01, 32'd20,        32'd0,       64'd2432902008176640000,  1'b0, 1'b0, 19};
        vecs[7]  = '{"fact_21_ovf", 2'b01, 32'd21,        32'd0,       64'd14197454024290336768, 1'b1, 1'b0, 20};
        vecs[8]  = '{"par_7",       2'b10, 32'h7,         32'hFFFF,    64'd1,                    1'b0, 1'b0, 1};
        vecs[9]  = '{"par_f",       2'b10, 32'hF,         32'd0,       64'd0,                    1'b0, 1'b0, 1};
        vecs[10] = '{"illegal",     2'b11, 32'd5,         32'd3,       64'd0,                    1'b0, 1'b1, 1};
        vecs[11] = '{"mult_0x5",    2'b00, 32'd0,         32'd5,       64'd0,                    1'b0, 1'b0, 32};
        vecs[12] = '{"mult_2p16sq", 2'b00, 32'h10000,     32'h10000,   64'h1_0000_0000,          1'b0, 1'b0, 32};
        vecs[13] = '{"fact_40_ovf", 2'b01, 32'd40,        32'd0,       64'd14197454024290336768, 1'b1, 1'b0, 20};

        #2;
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy",      {63'd0, busy},      64'd0);
        check("rst_result",    out_result,         64'd0);
        check("rst_ovf_err",   {62'd0, out_ovf, out_err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 14; v++) begin
            issue(vecs[v].mode, vecs[v].a, vecs[v].b, lat);
            check({vecs[v].name, "_lat"}, 64'(lat), 64'(vecs[v].lat));
            check({vecs[v].name, "_res"}, out_result, vecs[v].res);
            check({vecs[v].name, "_ovf"}, {63'd0, out_ovf}, {63'd0, vecs[v].ovf});
            check({vecs[v].name, "_err"}, {63'd0, out_err}, {63'd0, vecs[v].err});
            release_result();
            check({vecs[v].name, "_idle"}, {62'd0, in_ready, out_valid}, 64'd2);
        end

        // Backpressure: result held, new request ignored while busy.
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("bp_lat", 64'(lat), 64'd32);
        held = out_result;
        check("bp_res", held, 64'hFFFF_FFFE_0000_0001);
        in_mode  = 2'b10;
        in_a     = 32'h1;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("bp_hold_res", out_result, 64'hFFFF_FFFE_0000_0001);
            check("bp_hold_flags", {60'd0, out_valid, in_ready, busy, out_ovf}, 64'b1010);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release", {61'd0, in_ready, out_valid, busy}, 64'b100);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next_accept", {62'd0, in_ready, busy}, 64'b01);
        for (int k = 0; k < 5 && !out_valid; k++) begin
            @(posedge clk); #1;
        end
        check("bp_next_res", {out_result[62:0], out_valid}, {63'd1, 1'b1});
        release_result();

        // Asynchronous reset in the middle of a multiply.
        in_mode  = 2'b00;
        in_a     = 32'd123;
        in_b     = 32'd456;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
        end
        check("mid_busy", {63'd0, busy}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_outputs", {60'd0, out_valid, busy, out_ovf, out_err}, 64'd0);
        check("arst_in_ready", {63'd0, in_ready}, 64'd1);
        check("arst_result", out_result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid || busy) seen = 1'b1;
        end
        check("arst_no_valid", {63'd0, seen}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
